dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
2-way set-associative, write-back, write-allocate data cache controller sitting in the MEM stage. It is the responder to the pipeline's load/store requests and the initiator toward off-chip data memory. It produces cpu_stall_o, which freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB on a miss. Tag, dirty, valid and LRU state and the 256-bit line data are held internally.

Parameters:
INDEX_BITS, 4, set index width (16 sets)
LINE_BITS, 256, line size in bits (32 bytes, 8 words)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
start_i  in  1  synchronous active-low reset
cpu_addr_i  in  32  byte address; offset [4:0], index [4+INDEX_BITS:5], tag [31:5+INDEX_BITS]
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_o  out  32  load data
cpu_stall_o  out  1  pipeline stall
mem_data_i  in  256  line from memory
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_addr_o  out  32  line-aligned memory address, [4:0]=0
mem_data_o  out  256  write-back line
mem_enable_o  out  1  memory request
mem_write_o  out  1  1=write-back, 0=line fetch

Behaviour:
- req = MemRead | MemWrite. If both are high, the request is treated as a store. No req gives stall=0 and no state change.
- Hit: valid && tag match in either way, evaluated combinationally. Word = offset[4:2].
- Read hit: cpu_data_o = selected word in the same cycle; stall=0.
- Write hit: the word and dirty=1 are written at the next edge; stall=0.
- Every hit sets LRU[set] to point at the other way.
- cpu_stall_o = req && !hit in IDLE, and is 1 in every non-IDLE state. It is combinational, so it is asserted in the same cycle the miss is presented.
- Victim selection: way0 if invalid, else way1 if invalid, else LRU[set].
- FSM states: IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
  - IDLE -> MISS when req && !hit.
  - MISS (1 cycle, no memory request):
    - victim valid && dirty -> WRITEBACK
    - otherwise -> READMISS
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line. These are held until the mem_ack_i cycle inclusive; on ack -> READMISS.
  - READMISS: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}, held until ack. On ack: victim line=mem_data_i, tag=req tag, valid=1, dirty=0 -> READMISSOK.
  - READMISSOK (1 cycle) -> IDLE. The request, still held by the stalled pipeline, now hits in IDLE. A store is merged then and sets dirty. Stall drops that cycle.
- mem_enable_o and mem_write_o are 0 in IDLE, MISS and READMISSOK. mem_ack_i is ignored outside WRITEBACK/READMISS.
- Latency:
  - clean miss: stall for 3 + memory latency cycles before the hit cycle
  - dirty miss: adds the write-back round trip
- Reset (start_i=0 at an edge):
  - state=IDLE; all valid, dirty and LRU bits cleared. Data and tag arrays are not cleared.
  - While start_i=0, cpu_stall_o, cpu_data_o, mem_enable_o and mem_write_o are forced to 0.
  - Reset mid-miss aborts the transfer; a late mem_ack_i is ignored.
- cpu_data_o = 0 when there is no read hit.
- Requests to the same set in different ways never evict each other until a third tag maps to that set.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning line words 0..7 = 0x10..0x17 after 10 cycles -> stall high for 13 cycles, mem_addr_o=0x40, mem_write_o=0, then cpu_data_o=0x10 with stall low.
- Store 0xDEADBEEF to 0x44 (hit after the first test), then load 0x44 -> no stall, cpu_data_o=0xDEADBEEF.
- Load 0x240 and 0x440 (both index 2 with 0x40, a third tag) -> second miss evicts the LRU way holding 0x40. That way is dirty, so WRITEBACK is seen first: mem_write_o=1, mem_addr_o=0x40, mem_data_o word1=0xDEADBEEF, followed by READMISS mem_addr_o=0x440.
- Alternate loads 0x40 / 0x240 after both are filled -> no stall, no memory traffic, LRU toggles each access.
- Assert start_i=0 during READMISS, then pulse mem_ack_i -> FSM stays IDLE, mem_enable_o=0; the next load to 0x40 misses again.
- MemRead and MemWrite both high on a miss at 0x80 -> line fetch, then a store merge: dirty=1, and a later eviction writes back 0x80.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Bus bundle for the data cache controller: the pipeline load/store port on
// the cpu_* side and the off-chip line transfer port on the mem_* side.
// The slave modport is the cache controller itself. The master modport is its
// environment, meaning the pipeline and the memory model together.
interface dcache_ctrl_if #(
   parameter int LINE_BITS = 256
);
   logic [31:0]          cpu_addr_i;
   logic [31:0]          cpu_data_i;
   logic                 cpu_MemRead_i;
   logic                 cpu_MemWrite_i;
   logic [31:0]          cpu_data_o;
   logic                 cpu_stall_o;
   logic [LINE_BITS-1:0] mem_data_i;
   logic                 mem_ack_i;
   logic [31:0]          mem_addr_o;
   logic [LINE_BITS-1:0] mem_data_o;
   logic                 mem_enable_o;
   logic                 mem_write_o;

   modport slave (
      input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      input  mem_data_i, mem_ack_i,
      output cpu_data_o, cpu_stall_o,
      output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
   );

   modport master (
      output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
      output mem_data_i, mem_ack_i,
      input  cpu_data_o, cpu_stall_o,
      input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
   );
endinterface

// File: rtl/dcache_ctrl.sv
// 2-way set-associative, write-back, write-allocate data cache controller.
// Hits are resolved combinationally in IDLE. A miss walks the FSM through an
// optional victim write-back and then a line fetch. After that the request,
// still held by the stalled pipeline, hits on the cycle it returns to IDLE.
module dcache_ctrl #(
   parameter int INDEX_BITS = 4,
   parameter int LINE_BITS  = 256
) (
   input logic          clk_i,
   input logic          start_i,
   dcache_ctrl_if.slave bus
);

   localparam int SETS     = 1 << INDEX_BITS;
   localparam int TAG_BITS = 32 - 5 - INDEX_BITS;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_t;

   state_t state;
   state_t next_state;

   logic [LINE_BITS-1:0] data_arr [2][SETS];
   logic [TAG_BITS-1:0]  tag_arr  [2][SETS];
   logic [1:0]           valid    [SETS];
   logic [1:0]           dirty    [SETS];
   logic [SETS-1:0]      lru;

   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic [2:0]            word;
   logic                  req;
   logic                  is_load;
   logic                  is_store;
   logic                  hit0;
   logic                  hit1;
   logic                  hit;
   logic                  hit_way;
   logic [LINE_BITS-1:0]  hit_line;
   logic [31:0]           hit_word;
   logic                  victim_sel;
   logic                  victim_q;
   logic [LINE_BITS-1:0]  victim_line;
   logic [TAG_BITS-1:0]   victim_tag;
   logic                  idle_hit;
   logic                  fill;

   logic                  stall;
   logic [31:0]           read_data;
   logic                  mem_req;
   logic                  mem_wr;
   logic [31:0]           line_addr;
   logic [LINE_BITS-1:0]  wb_line;

   assign index    = bus.cpu_addr_i[4+INDEX_BITS:5];
   assign tag      = bus.cpu_addr_i[31:5+INDEX_BITS];
   assign word     = bus.cpu_addr_i[4:2];
   assign req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
   assign is_store = bus.cpu_MemWrite_i;
   assign is_load  = bus.cpu_MemRead_i & ~bus.cpu_MemWrite_i;

   assign hit0     = valid[index][0] && (tag_arr[0][index] == tag);
   assign hit1     = valid[index][1] && (tag_arr[1][index] == tag);
   assign hit      = hit0 | hit1;
   assign hit_way  = ~hit0;
   assign hit_line = data_arr[hit_way][index];
   assign hit_word = hit_line[{word, 5'b00000} +: 32];

   assign victim_sel  = !valid[index][0] ? 1'b0 :
                        !valid[index][1] ? 1'b1 : lru[index];
   assign victim_line = data_arr[victim_q][index];
   assign victim_tag  = tag_arr[victim_q][index];

   assign idle_hit = start_i && (state == IDLE) && req && hit;
   assign fill     = start_i && (state == READMISS) && bus.mem_ack_i;

   // State register and the victim way chosen when a miss leaves IDLE
   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         state    <= IDLE;
         victim_q <= 1'b0;
      end else begin
         state <= next_state;
         if ((state == IDLE) && req && !hit) begin
            victim_q <= victim_sel;
         end
      end
   end

   // Next-state logic plus stall, load data and memory request outputs
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      read_data  = '0;
      mem_req    = 1'b0;
      mem_wr     = 1'b0;
      line_addr  = '0;
      wb_line    = '0;
      case (state)
         IDLE: begin
            if (req && !hit) begin
               stall      = 1'b1;
               next_state = MISS;
            end else if (req && is_load) begin
               read_data = hit_word;
            end
         end
         MISS: begin
            stall = 1'b1;
            if (valid[index][victim_q] && dirty[index][victim_q]) begin
               next_state = WRITEBACK;
            end else begin
               next_state = READMISS;
            end
         end
         WRITEBACK: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            line_addr = {victim_tag, index, 5'b00000};
            wb_line   = victim_line;
            if (bus.mem_ack_i) begin
               next_state = READMISS;
            end
         end
         READMISS: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            line_addr = {tag, index, 5'b00000};
            if (bus.mem_ack_i) begin
               next_state = READMISSOK;
            end
         end
         READMISSOK: begin
            stall      = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      if (!start_i) begin
         stall     = 1'b0;
         read_data = '0;
         mem_req   = 1'b0;
         mem_wr    = 1'b0;
         line_addr = '0;
         wb_line   = '0;
      end
   end

   // Valid, dirty and LRU bookkeeping; these are the only arrays reset clears
   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         valid <= '{default: 2'b00};
         dirty <= '{default: 2'b00};
         lru   <= '0;
      end else begin
         if (idle_hit) begin
            lru[index] <= ~hit_way;
            if (is_store) begin
               dirty[index][hit_way] <= 1'b1;
            end
         end
         if (fill) begin
            valid[index][victim_q] <= 1'b1;
            dirty[index][victim_q] <= 1'b0;
         end
      end
   end

   // Line data and tag storage: store merges on a hit, whole line on a fill
   always_ff @(posedge clk_i) begin
      if (start_i) begin
         if (idle_hit && is_store) begin
            data_arr[hit_way][index][{word, 5'b00000} +: 32] <= bus.cpu_data_i;
         end
         if (fill) begin
            data_arr[victim_q][index] <= bus.mem_data_i;
            tag_arr[victim_q][index]  <= tag;
         end
      end
   end

   assign bus.cpu_stall_o  = stall;
   assign bus.cpu_data_o   = read_data;
   assign bus.mem_enable_o = mem_req;
   assign bus.mem_write_o  = mem_wr;
   assign bus.mem_addr_o   = line_addr;
   assign bus.mem_data_o   = wb_line;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl. A word-level golden model tracks what
// the memory system should hold. Load results and memory transactions are
// queued when a request is driven and compared when the cache delivers them.
module tb_dcache_ctrl;

   localparam int LAT = 10;

   typedef struct {
      logic [31:0]  addr;
      logic         write;
      logic [255:0] data;
   } mem_txn_t;

   logic clk = 1'b0;
   logic start;

   dcache_ctrl_if #(.LINE_BITS(256)) bus ();

   dcache_ctrl #(
      .INDEX_BITS(4),
      .LINE_BITS (256)
   ) dut (
      .clk_i  (clk),
      .start_i(start),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0]  gold      [int unsigned];
   logic [255:0] mem_store [int unsigned];
   logic [31:0]  exp_load  [$];
   mem_txn_t     exp_mem   [$];

   bit mem_auto   = 1'b1;
   bit manual_ack = 1'b0;
   int s;

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] gold_word(input int unsigned wa);
      if (gold.exists(wa)) return gold[wa];
      return 32'(wa);
   endfunction

   function automatic logic [255:0] gold_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) begin
         l[w*32 +: 32] = gold_word(int'(la >> 2) + w);
      end
      return l;
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] la);
      logic [255:0] l;
      if (mem_store.exists(la)) return mem_store[la];
      for (int w = 0; w < 8; w++) begin
         l[w*32 +: 32] = (la >> 2) + 32'(w);
      end
      return l;
   endfunction

   task automatic expect_mem(input logic [31:0] addr, input logic write);
      mem_txn_t t;
      t.addr  = addr;
      t.write = write;
      t.data  = write ? gold_line(addr) : '0;
      exp_mem.push_back(t);
   endtask

   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                output int stalls);
      int unsigned wa;
      wa = addr >> 2;
      if (wr) begin
         gold[wa] = data;
         exp_load.push_back(32'h0);
      end else begin
         exp_load.push_back(gold_word(wa));
      end
      bus.cpu_addr_i     = addr;
      bus.cpu_data_i     = data;
      bus.cpu_MemRead_i  = rd;
      bus.cpu_MemWrite_i = wr;
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!bus.cpu_stall_o) break;
         stalls++;
         if (stalls >= 400) begin
            checkOutput("stall_bound", {255'b0, bus.cpu_stall_o}, 256'h0);
            break;
         end
      end
      checkOutput("cpu_data", bus.cpu_data_o, exp_load.pop_front());
      @(posedge clk);
      #1;
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
   endtask

   // Memory model: acks LAT cycles into a request and scores each transfer
   initial begin
      int cnt;
      mem_txn_t e;
      cnt = 0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack_i = 1'b0;
         if (!mem_auto) begin
            cnt = 0;
            bus.mem_ack_i = manual_ack;
         end else if (bus.mem_enable_o) begin
            cnt++;
            if (cnt == LAT) begin
               cnt = 0;
               checkOutput("mem_txn_pending", {255'b0, exp_mem.size() != 0}, 256'h1);
               if (exp_mem.size() != 0) begin
                  e = exp_mem.pop_front();
                  checkOutput("mem_addr", bus.mem_addr_o, e.addr);
                  checkOutput("mem_write", {255'b0, bus.mem_write_o}, {255'b0, e.write});
                  if (e.write) begin
                     checkOutput("wb_line", bus.mem_data_o, e.data);
                  end
               end
               if (bus.mem_write_o) begin
                  mem_store[bus.mem_addr_o] = bus.mem_data_o;
               end else begin
                  bus.mem_data_i = mem_line(bus.mem_addr_o);
               end
               bus.mem_ack_i = 1'b1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Watchdog so a wedged run still ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      start              = 1'b0;
      bus.cpu_addr_i     = 32'h40;
      bus.cpu_data_i     = '0;
      bus.cpu_MemRead_i  = 1'b1;
      bus.cpu_MemWrite_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_stall", {255'b0, bus.cpu_stall_o}, 256'h0);
      checkOutput("reset_mem_enable", {255'b0, bus.mem_enable_o}, 256'h0);
      checkOutput("reset_cpu_data", bus.cpu_data_o, 256'h0);
      @(posedge clk);
      #1;
      bus.cpu_MemRead_i = 1'b0;
      start = 1'b1;
      @(negedge clk);
      checkOutput("idle_stall", {255'b0, bus.cpu_stall_o}, 256'h0);
      checkOutput("idle_mem_enable", {255'b0, bus.mem_enable_o}, 256'h0);
      @(posedge clk);
      #1;

      $display("[TB] clean load miss at 0x40");
      expect_mem(32'h40, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, s);
      checkOutput("clean_miss_stall", s, 13);

      $display("[TB] store hit then load hit at 0x44");
      applyStimulus(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, s);
      checkOutput("store_hit_stall", s, 0);
      applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, s);
      checkOutput("load_hit_stall", s, 0);

      $display("[TB] third tag in set 2 evicts dirty 0x40");
      expect_mem(32'h240, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h240, 32'h0, s);
      checkOutput("second_way_stall", s, 13);
      expect_mem(32'h40, 1'b1);
      expect_mem(32'h440, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h440, 32'h0, s);
      checkOutput("dirty_miss_stall", s, 23);

      $display("[TB] refill 0x40 and 0x240 then alternate");
      expect_mem(32'h40, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, s);
      checkOutput("refill_40_stall", s, 13);
      expect_mem(32'h240, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h240, 32'h0, s);
      checkOutput("refill_240_stall", s, 13);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 32'h40 : 32'h240, 32'h0, s);
         checkOutput("alternate_stall", s, 0);
      end

      $display("[TB] reset during READMISS");
      mem_auto           = 1'b0;
      bus.cpu_addr_i     = 32'h840;
      bus.cpu_MemRead_i  = 1'b1;
      bus.cpu_MemWrite_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.mem_enable_o) break;
      end
      checkOutput("abort_rm_enable", {255'b0, bus.mem_enable_o}, 256'h1);
      checkOutput("abort_rm_write", {255'b0, bus.mem_write_o}, 256'h0);
      checkOutput("abort_rm_addr", bus.mem_addr_o, 32'h840);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("abort_reset_stall", {255'b0, bus.cpu_stall_o}, 256'h0);
      checkOutput("abort_reset_enable", {255'b0, bus.mem_enable_o}, 256'h0);
      @(posedge clk);
      #1;
      bus.cpu_MemRead_i = 1'b0;
      @(posedge clk);
      #1;
      start      = 1'b1;
      manual_ack = 1'b1;
      @(negedge clk);
      checkOutput("late_ack_enable", {255'b0, bus.mem_enable_o}, 256'h0);
      @(posedge clk);
      #1;
      manual_ack = 1'b0;
      @(negedge clk);
      checkOutput("after_ack_enable", {255'b0, bus.mem_enable_o}, 256'h0);
      checkOutput("after_ack_stall", {255'b0, bus.cpu_stall_o}, 256'h0);
      @(posedge clk);
      #1;
      mem_auto = 1'b1;
      expect_mem(32'h40, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, s);
      checkOutput("post_reset_miss_stall", s, 13);

      $display("[TB] read+write miss at 0x80 merges a store");
      expect_mem(32'h80, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, s);
      checkOutput("rw_miss_stall", s, 13);
      applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, s);
      checkOutput("rw_load_stall", s, 0);
      expect_mem(32'h280, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h280, 32'h0, s);
      expect_mem(32'h80, 1'b1);
      expect_mem(32'h480, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h480, 32'h0, s);
      checkOutput("rw_evict_stall", s, 23);

      checkOutput("mem_queue_drained", exp_mem.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
